// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and flush bubbling.
// Define ID_EX_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_busA,
  input  logic [31:0] id_busB,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_RegWr,
  input  logic        id_MemRead,
  input  logic        id_MemWr,
  input  logic        id_MemtoReg,
  input  logic        id_RegDst,
  input  logic        id_ALUSrc,
  input  logic [3:0]  id_ALUctr,
  input  logic        ex_flush,
  output logic        ID_Ex_valid,
  output logic [31:0] ID_Ex_pc,
  output logic [31:0] ID_Ex_busA,
  output logic [31:0] ID_Ex_busB,
  output logic [31:0] ID_Ex_imm,
  output logic [4:0]  ID_Ex_Rs,
  output logic [4:0]  ID_Ex_Rt,
  output logic [4:0]  ID_Ex_Rw,
  output logic        ID_Ex_RegWr,
  output logic        ID_Ex_MemRead,
  output logic        ID_Ex_MemWr,
  output logic        ID_Ex_MemtoReg,
  output logic        ID_Ex_ALUSrc,
  output logic [3:0]  ID_Ex_ALUctr,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        stall
);

  logic        valid_d,    valid_q;
  logic [31:0] pc_d,       pc_q;
  logic [31:0] busa_d,     busa_q;
  logic [31:0] busb_d,     busb_q;
  logic [31:0] imm_d,      imm_q;
  logic [4:0]  rs_d,       rs_q;
  logic [4:0]  rt_d,       rt_q;
  logic [4:0]  rw_d,       rw_q;
  logic        regwr_d,    regwr_q;
  logic        memread_d,  memread_q;
  logic        memwr_d,    memwr_q;
  logic        memtoreg_d, memtoreg_q;
  logic        alusrc_d,   alusrc_q;
  logic [3:0]  aluctr_d,   aluctr_q;
  logic        stall_s;
  logic        bubble_s;
  logic [4:0]  id_rw_s;

  // Load-use detection; both sources are compared even when rt is not read, and flush wins.
  always_comb begin
    id_rw_s  = id_RegDst ? id_rd : id_rt;
    stall_s  = id_valid & valid_q & memread_q & (rw_q != 5'd0) &
               ((rw_q == id_rs) | (rw_q == id_rt)) & ~ex_flush;
    bubble_s = stall_s | ex_flush | ~id_valid;
  end

  // Next-state for the pipeline register; a bubble kills side effects and register tags.
  always_comb begin
    pc_d       = id_pc;
    busa_d     = id_busA;
    busb_d     = id_busB;
    imm_d      = id_imm;
    memtoreg_d = id_MemtoReg;
    alusrc_d   = id_ALUSrc;
    aluctr_d   = id_ALUctr;
    if (bubble_s) begin
      valid_d   = 1'b0;
      regwr_d   = 1'b0;
      memread_d = 1'b0;
      memwr_d   = 1'b0;
      rs_d      = 5'd0;
      rt_d      = 5'd0;
      rw_d      = 5'd0;
    end else begin
      valid_d   = 1'b1;
      regwr_d   = id_RegWr;
      memread_d = id_MemRead;
      memwr_d   = id_MemWr;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rw_d      = id_rw_s;
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= 32'd0;
      busa_q     <= 32'd0;
      busb_q     <= 32'd0;
      imm_q      <= 32'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      rw_q       <= 5'd0;
      regwr_q    <= 1'b0;
      memread_q  <= 1'b0;
      memwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluctr_q   <= 4'd0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      busa_q     <= busa_d;
      busb_q     <= busb_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rw_q       <= rw_d;
      regwr_q    <= regwr_d;
      memread_q  <= memread_d;
      memwr_q    <= memwr_d;
      memtoreg_q <= memtoreg_d;
      alusrc_q   <= alusrc_d;
      aluctr_q   <= aluctr_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // Free-running event counters, wrapping modulo 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + (stall_s  ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (ex_flush ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  assign stall          = stall_s;
  assign ID_Ex_valid    = valid_q;
  assign ID_Ex_pc       = pc_q;
  assign ID_Ex_busA     = busa_q;
  assign ID_Ex_busB     = busb_q;
  assign ID_Ex_imm      = imm_q;
  assign ID_Ex_Rs       = rs_q;
  assign ID_Ex_Rt       = rt_q;
  assign ID_Ex_Rw       = rw_q;
  assign ID_Ex_RegWr    = regwr_q;
  assign ID_Ex_MemRead  = memread_q;
  assign ID_Ex_MemWr    = memwr_q;
  assign ID_Ex_MemtoReg = memtoreg_q;
  assign ID_Ex_ALUSrc   = alusrc_q;
  assign ID_Ex_ALUctr   = aluctr_q;

endmodule
